// File: rtl/ctrl_pkg.sv
// Shared encodings, control-word layout and size helpers for the RV32 ID/EX control unit.
// The M-extension decode is enabled by the RV32M_EN macro in the files that import this package.
package ctrl_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SLL = 5'b00001;
  localparam logic [4:0] ALU_SRL = 5'b00101;
  localparam logic [4:0] ALU_SUB = 5'b10000;
  localparam logic [4:0] ALU_SRA = 5'b10101;
  localparam logic [4:0] ALU_FWD = 5'b11110;
  localparam logic [1:0] PFX_INT = 2'b00;
  localparam logic [1:0] PFX_BR  = 2'b01;
  localparam logic [1:0] PFX_M   = 2'b11;

  localparam logic [2:0] MEM_NONE = 3'b000;
  localparam logic [2:0] MEM_B    = 3'b001;
  localparam logic [2:0] MEM_H    = 3'b010;
  localparam logic [2:0] MEM_W    = 3'b011;
  localparam logic [2:0] MEM_BU   = 3'b100;
  localparam logic [2:0] MEM_HU   = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] SRC_REG = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;

  typedef enum logic [1:0] {M_NONE = 2'b00, M_MUL = 2'b01, M_DIV = 2'b10} m_kind_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_MBUSY = 1'b1} mstate_e;

  typedef struct packed {
    logic [4:0] alu_op;
    logic [2:0] mem_read;
    logic [2:0] mem_write;
    logic [2:0] immi_sel;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_source;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       pc_sel;
    logic       illegal;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;
  localparam ctrl_word_t CTRL_ILLEGAL = '{alu_op: ALU_ADD, mem_read: MEM_NONE, mem_write: MEM_NONE,
                                         immi_sel: IMM_I, mem_to_reg: WB_ALU, alu_source: SRC_REG,
                                         reg_write: 1'b0, branch: 1'b0, jump: 1'b0, pc_sel: 1'b0,
                                         illegal: 1'b1};

  // MEM_NONE flags a reserved load width
  function automatic logic [2:0] load_size(input logic [2:0] fun3);
    logic [2:0] size;
    case (fun3)
      3'b000:  size = MEM_B;
      3'b001:  size = MEM_H;
      3'b010:  size = MEM_W;
      3'b100:  size = MEM_BU;
      3'b101:  size = MEM_HU;
      default: size = MEM_NONE;
    endcase
    return size;
  endfunction

  function automatic logic [2:0] store_size(input logic [2:0] fun3);
    logic [2:0] size;
    case (fun3)
      3'b000:  size = MEM_B;
      3'b001:  size = MEM_H;
      3'b010:  size = MEM_W;
      default: size = MEM_NONE;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational OP/FUN3/FUN7 decoder producing the control word and M-op latency class.
// M ops decode only when RV32M_EN is defined; otherwise FUN7=0000001 is illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] fun3,
  input  logic [6:0] fun7,
  output ctrl_word_t word,
  output m_kind_e    m_kind
);

  // Decode table; any reserved encoding collapses to the illegal word
  always_comb begin
    word   = CTRL_BUBBLE;
    m_kind = M_NONE;
    case (op)
      OPC_RTYPE: begin
        word.reg_write = 1'b1;
        case (fun7)
          F7_BASE: word.alu_op = {PFX_INT, fun3};
          F7_ALT: begin
            if (fun3 == 3'b000) begin
              word.alu_op = ALU_SUB;
            end else if (fun3 == 3'b101) begin
              word.alu_op = ALU_SRA;
            end else begin
              word = CTRL_ILLEGAL;
            end
          end
          F7_MULDIV: begin
`ifdef RV32M_EN
            word.alu_op = {PFX_M, fun3};
            m_kind      = fun3[2] ? M_DIV : M_MUL;
`else
            word = CTRL_ILLEGAL;
`endif
          end
          default: word = CTRL_ILLEGAL;
        endcase
      end
      OPC_IALU: begin
        word.reg_write  = 1'b1;
        word.alu_source = SRC_IMM;
        word.immi_sel   = IMM_I;
        // Only the shift-immediates carry a real funct7; elsewhere it is immediate data
        case (fun3)
          3'b001: begin
            if (fun7 == F7_BASE) begin
              word.alu_op = ALU_SLL;
            end else begin
              word = CTRL_ILLEGAL;
            end
          end
          3'b101: begin
            if (fun7 == F7_BASE) begin
              word.alu_op = ALU_SRL;
            end else if (fun7 == F7_ALT) begin
              word.alu_op = ALU_SRA;
            end else begin
              word = CTRL_ILLEGAL;
            end
          end
          default: word.alu_op = {PFX_INT, fun3};
        endcase
      end
      OPC_LOAD: begin
        if (load_size(fun3) == MEM_NONE) begin
          word = CTRL_ILLEGAL;
        end else begin
          word.mem_read   = load_size(fun3);
          word.mem_to_reg = WB_MEM;
          word.alu_source = SRC_IMM;
          word.reg_write  = 1'b1;
        end
      end
      OPC_STORE: begin
        if (store_size(fun3) == MEM_NONE) begin
          word = CTRL_ILLEGAL;
        end else begin
          word.mem_write  = store_size(fun3);
          word.immi_sel   = IMM_S;
          word.alu_source = SRC_IMM;
        end
      end
      OPC_BRANCH: begin
        if (fun3 == 3'b010 || fun3 == 3'b011) begin
          word = CTRL_ILLEGAL;
        end else begin
          word.branch   = 1'b1;
          word.alu_op   = {PFX_BR, fun3};
          word.immi_sel = IMM_B;
        end
      end
      OPC_LUI: begin
        word.alu_op     = ALU_FWD;
        word.immi_sel   = IMM_U;
        word.alu_source = SRC_IMM;
        word.reg_write  = 1'b1;
      end
      OPC_AUIPC: begin
        word.pc_sel     = 1'b1;
        word.immi_sel   = IMM_U;
        word.alu_source = SRC_IMM;
        word.reg_write  = 1'b1;
      end
      OPC_JAL: begin
        word.jump       = 1'b1;
        word.pc_sel     = 1'b1;
        word.immi_sel   = IMM_J;
        word.mem_to_reg = WB_PC4;
        word.alu_source = SRC_IMM;
        word.reg_write  = 1'b1;
      end
      OPC_JALR: begin
        if (fun3 != 3'b000) begin
          word = CTRL_ILLEGAL;
        end else begin
          word.jump       = 1'b1;
          word.immi_sel   = IMM_I;
          word.mem_to_reg = WB_PC4;
          word.alu_source = SRC_IMM;
          word.reg_write  = 1'b1;
        end
      end
      default: word = CTRL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/ctrl_unit_pipe.sv
// ID/EX control stage: decoder, valid/ready pipeline register and multi-cycle M-op busy tracker.
// Define RV32M_EN to enable M-extension decode and the busy FSM.
module ctrl_unit_pipe
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 5,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [6:0]          OP,
  input  logic [2:0]          FUN3,
  input  logic [6:0]          FUN7,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic                STALL,
  input  logic                FLUSH,
  output logic                OUT_VALID,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic [2:0]          MEM_READ,
  output logic [2:0]          MEM_WRITE,
  output logic [2:0]          IMMI_SEL,
  output logic [1:0]          MEM_TO_REG,
  output logic [1:0]          ALU_SOURCE,
  output logic                REG_WRITE,
  output logic                BRANCH,
  output logic                JUMP,
  output logic                PC_SEL,
  output logic                ILLEGAL,
  output logic                M_BUSY
);

  ctrl_word_t dec_word_s;
  m_kind_e    dec_m_kind_s;
  ctrl_word_t ctrl_r;
  logic       out_valid_r;
  logic       m_busy_s;

  ctrl_decode u_decode (
    .op     (OP),
    .fun3   (FUN3),
    .fun7   (FUN7),
    .word   (dec_word_s),
    .m_kind (dec_m_kind_s)
  );

  assign IN_READY = !STALL && !m_busy_s;

  // ID/EX control register; flush beats stall, busy holds like a stall
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_r      <= CTRL_BUBBLE;
      out_valid_r <= 1'b0;
    end else if (FLUSH) begin
      ctrl_r      <= CTRL_BUBBLE;
      out_valid_r <= 1'b0;
    end else if (STALL || m_busy_s) begin
      ctrl_r      <= ctrl_r;
      out_valid_r <= out_valid_r;
    end else if (IN_VALID) begin
      ctrl_r      <= dec_word_s;
      out_valid_r <= 1'b1;
    end else begin
      ctrl_r      <= CTRL_BUBBLE;
      out_valid_r <= 1'b0;
    end
  end

`ifdef RV32M_EN
  mstate_e          state_r;
  mstate_e          state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] lat_m1_s;
  logic             m_start_s;

  // A flushed M op never reaches EX, so it must not start the tracker
  assign m_start_s = IN_VALID && IN_READY && !FLUSH && (dec_m_kind_s != M_NONE);
  assign lat_m1_s  = (dec_m_kind_s == M_DIV) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

  // Busy FSM state and countdown register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Busy FSM next state; the count runs down regardless of stall or flush
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (m_start_s && (lat_m1_s != '0)) begin
          state_nxt_s = ST_MBUSY;
          cnt_nxt_s   = lat_m1_s;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = cnt_r;
        end
      end
      ST_MBUSY: begin
        cnt_nxt_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_MBUSY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Busy FSM outputs
  always_comb begin
    m_busy_s = 1'b0;
    case (state_r)
      ST_MBUSY: m_busy_s = 1'b1;
      default:  m_busy_s = 1'b0;
    endcase
  end
`else
  logic [31:0] unused_s;

  assign m_busy_s = 1'b0;
  assign unused_s = {30'd0, dec_m_kind_s} ^ 32'(MUL_LAT) ^ 32'(DIV_LAT) ^ 32'(CNT_W);
`endif

  assign OUT_VALID  = out_valid_r;
  assign ALU_OP     = ALU_OP_W'(ctrl_r.alu_op);
  assign MEM_READ   = ctrl_r.mem_read;
  assign MEM_WRITE  = ctrl_r.mem_write;
  assign IMMI_SEL   = ctrl_r.immi_sel;
  assign MEM_TO_REG = ctrl_r.mem_to_reg;
  assign ALU_SOURCE = ctrl_r.alu_source;
  assign REG_WRITE  = ctrl_r.reg_write;
  assign BRANCH     = ctrl_r.branch;
  assign JUMP       = ctrl_r.jump;
  assign PC_SEL     = ctrl_r.pc_sel;
  assign ILLEGAL    = ctrl_r.illegal;
  assign M_BUSY     = m_busy_s;

endmodule
